// File: rtl/game_move_sequencer.sv
// ============================================================================
// game_move_sequencer
// ----------------------------------------------------------------------------
// Owns the 4x4 2048 board register and sequences each move:
//    LINE  : slide/merge one row or column per cycle (4 cycles)
//    SPAWN : place a new 2 or 4 tile, scanning from an LFSR-chosen cell
//    CHECK : evaluate game-over, then return to IDLE
// After reset the block spawns two tiles (INIT) before accepting moves.
//
// Ports
//    clk           in   clock
//    rst           in   asynchronous active-high reset
//    move_valid    in   move request
//    move_dir      in   00 up, 01 right, 10 down, 11 left
//    move_ready    out  idle and not game over
//    cfg_load      in   load cfg_board (accepted in IDLE only, wins over moves)
//    cfg_board     in   board image, cell(r,c) at [(r*4+c)*CELL_W +: CELL_W]
//    board         out  current board, same packing as cfg_board
//    score         out  accumulated merge score (saturating)
//    busy          out  state is not IDLE
//    move_done     out  one-cycle pulse at the end of a move
//    move_changed  out  board changed by the move, valid with move_done
//    game_over     out  sticky until rst or cfg_load
// ============================================================================
module game_move_sequencer #(
   parameter int          CELL_W    = 20,
   parameter int          SCORE_W   = 21,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   move_valid,
   input  logic [1:0]             move_dir,
   output logic                   move_ready,
   input  logic                   cfg_load,
   input  logic [16*CELL_W-1:0]   cfg_board,
   output logic [16*CELL_W-1:0]   board,
   output logic [SCORE_W-1:0]     score,
   output logic                   busy,
   output logic                   move_done,
   output logic                   move_changed,
   output logic                   game_over
);

   localparam int BOARD_W = 16 * CELL_W;
   localparam logic [CELL_W-1:0] VAL_TWO  = {{(CELL_W-2){1'b0}}, 2'b10};
   localparam logic [CELL_W-1:0] VAL_FOUR = {{(CELL_W-3){1'b0}}, 3'b100};

   typedef logic [3:0][CELL_W-1:0] line_t;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_LINE  = 3'd2,
      S_SPAWN = 3'd3,
      S_CHECK = 3'd4
   } state_t;

   // Board index of element j of line k, element 0 sitting on the destination edge.
   function automatic logic [3:0] line_idx(input logic [1:0] dir,
                                           input logic [1:0] k,
                                           input logic [1:0] j);
      logic [3:0] idx;
      case (dir)
         2'b00:   idx = {j, k};     // up: column k, row j
         2'b01:   idx = {k, ~j};    // right: row k, column 3-j
         2'b10:   idx = {~j, k};    // down: column k, row 3-j
         2'b11:   idx = {k, j};     // left: row k, column j
         default: idx = {k, j};
      endcase
      return idx;
   endfunction

   // Compact toward element 0, then merge equal neighbours front-first.
   // The skip flag makes a merged result unavailable for a second merge.
   // Cells with the top bit set never merge, so doubling cannot overflow.
   function automatic line_t slide_line(input line_t cin,
                                        output logic [SCORE_W-1:0] gain);
      logic [4:0][CELL_W-1:0] comp;
      logic [4:0][CELL_W-1:0] res;
      logic [2:0]             w;
      logic                   skip;
      comp = '0;
      res  = '0;
      gain = '0;
      skip = 1'b0;
      w    = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (cin[i] != '0) begin
            comp[w] = cin[i];
            w       = w + 3'd1;
         end else begin
            w = w;
         end
      end
      w = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if ((comp[i] != '0) && (comp[i] == comp[i+1]) &&
                      !comp[i][CELL_W-1]) begin
            res[w] = comp[i] << 1;
            gain   = gain + SCORE_W'(comp[i] << 1);
            w      = w + 3'd1;
            skip   = 1'b1;
         end else begin
            res[w] = comp[i];
            w      = w + 3'd1;
         end
      end
      return res[3:0];
   endfunction

   state_t               state_q, state_d;
   logic [BOARD_W-1:0]   board_q, board_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 game_over_q, game_over_d;
   logic                 move_done_q, move_done_d;
   logic                 move_changed_q, move_changed_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [1:0]           dir_q, dir_d;
   logic [1:0]           line_q, line_d;
   logic                 moved_q, moved_d;
   logic                 in_move_q, in_move_d;
   logic                 init_q, init_d;
   logic                 second_q, second_d;
   logic [3:0]           spawn_cnt_q, spawn_cnt_d;
   logic [3:0]           spawn_idx_q, spawn_idx_d;
   logic [CELL_W-1:0]    spawn_val_q, spawn_val_d;

   logic [3:0][3:0]      line_pos;
   line_t                line_in, line_out;
   logic [SCORE_W-1:0]   line_gain;
   logic [BOARD_W-1:0]   line_board;
   logic                 line_changed;
   logic [SCORE_W:0]     score_sum;
   logic [SCORE_W-1:0]   score_sat;
   logic                 any_empty, any_pair;
   logic                 spawn_first, spawn_hit;
   logic [3:0]           spawn_cur_idx;
   logic [CELL_W-1:0]    spawn_cur_val;

   // Slide/merge datapath for the line selected by dir_q and line_q.
   always_comb begin
      line_board = board_q;
      for (int j = 0; j < 4; j++) begin
         line_pos[j] = line_idx(dir_q, line_q, 2'(j));
         line_in[j]  = board_q[line_pos[j]*CELL_W +: CELL_W];
      end
      line_out = slide_line(line_in, line_gain);
      for (int j = 0; j < 4; j++) begin
         line_board[line_pos[j]*CELL_W +: CELL_W] = line_out[j];
      end
      line_changed = (line_out != line_in);
      score_sum    = {1'b0, score_q} + {1'b0, line_gain};
      score_sat    = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
   end

   // Board status for the game-over test: any empty cell, any equal neighbours.
   always_comb begin
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         any_empty = any_empty | (board_q[i*CELL_W +: CELL_W] == '0);
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            any_pair = any_pair |
               (board_q[(r*4+c)*CELL_W +: CELL_W] == board_q[(r*4+c+1)*CELL_W +: CELL_W]);
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            any_pair = any_pair |
               (board_q[(r*4+c)*CELL_W +: CELL_W] == board_q[((r+1)*4+c)*CELL_W +: CELL_W]);
         end
      end
   end

   // Spawn probe: the first scan cycle takes position and value from the LFSR.
   always_comb begin
      spawn_first   = (spawn_cnt_q == 4'd0);
      spawn_cur_idx = spawn_first ? lfsr_q[3:0] : spawn_idx_q;
      spawn_cur_val = spawn_first ? ((lfsr_q[7:4] == 4'd0) ? VAL_FOUR : VAL_TWO)
                                  : spawn_val_q;
      spawn_hit     = (board_q[spawn_cur_idx*CELL_W +: CELL_W] == '0);
   end

   // Next-state and register-input logic for the move sequencer.
   always_comb begin
      state_d        = state_q;
      board_d        = board_q;
      score_d        = score_q;
      game_over_d    = game_over_q;
      move_done_d    = 1'b0;
      move_changed_d = 1'b0;
      lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dir_d          = dir_q;
      line_d         = line_q;
      moved_d        = moved_q;
      in_move_d      = in_move_q;
      init_d         = init_q;
      second_d       = second_q;
      spawn_cnt_d    = spawn_cnt_q;
      spawn_idx_d    = spawn_idx_q;
      spawn_val_d    = spawn_val_q;

      case (state_q)
         S_INIT: begin
            init_d      = 1'b1;
            second_d    = 1'b0;
            in_move_d   = 1'b0;
            spawn_cnt_d = 4'd0;
            state_d     = S_SPAWN;
         end

         S_IDLE: begin
            if (cfg_load) begin
               board_d     = cfg_board;
               score_d     = '0;
               game_over_d = 1'b0;
               in_move_d   = 1'b0;
               state_d     = S_CHECK;
            end else if (move_valid && !game_over_q) begin
               dir_d     = move_dir;
               line_d    = 2'd0;
               moved_d   = 1'b0;
               in_move_d = 1'b1;
               state_d   = S_LINE;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_LINE: begin
            board_d = line_board;
            score_d = score_sat;
            moved_d = moved_q | line_changed;
            line_d  = line_q + 2'd1;
            if (line_q == 2'd3) begin
               if (moved_d) begin
                  state_d = S_SPAWN;
               end else begin
                  // Nothing moved: finish without spawning or checking.
                  state_d        = S_IDLE;
                  move_done_d    = 1'b1;
                  move_changed_d = 1'b0;
                  in_move_d      = 1'b0;
               end
            end else begin
               state_d = S_LINE;
            end
         end

         S_SPAWN: begin
            spawn_val_d = spawn_cur_val;
            spawn_idx_d = spawn_cur_idx + 4'd1;
            if (spawn_hit) begin
               board_d[spawn_cur_idx*CELL_W +: CELL_W] = spawn_cur_val;
            end else begin
               board_d = board_q;
            end
            // Ends on a write, or after 16 probes of a full board.
            if (spawn_hit || (spawn_cnt_q == 4'd15)) begin
               spawn_cnt_d = 4'd0;
               if (init_q && !second_q) begin
                  second_d = 1'b1;
                  state_d  = S_SPAWN;
               end else begin
                  state_d = S_CHECK;
               end
            end else begin
               spawn_cnt_d = spawn_cnt_q + 4'd1;
               state_d     = S_SPAWN;
            end
         end

         S_CHECK: begin
            game_over_d = game_over_q | (!any_empty && !any_pair);
            if (in_move_q) begin
               move_done_d    = 1'b1;
               move_changed_d = moved_q;
            end else begin
               move_done_d    = 1'b0;
               move_changed_d = 1'b0;
            end
            in_move_d = 1'b0;
            init_d    = 1'b0;
            second_d  = 1'b0;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_INIT;
         board_q        <= '0;
         score_q        <= '0;
         game_over_q    <= 1'b0;
         move_done_q    <= 1'b0;
         move_changed_q <= 1'b0;
         lfsr_q         <= LFSR_SEED;
         dir_q          <= 2'b00;
         line_q         <= 2'd0;
         moved_q        <= 1'b0;
         in_move_q      <= 1'b0;
         init_q         <= 1'b0;
         second_q       <= 1'b0;
         spawn_cnt_q    <= 4'd0;
         spawn_idx_q    <= 4'd0;
         spawn_val_q    <= '0;
      end else begin
         state_q        <= state_d;
         board_q        <= board_d;
         score_q        <= score_d;
         game_over_q    <= game_over_d;
         move_done_q    <= move_done_d;
         move_changed_q <= move_changed_d;
         lfsr_q         <= lfsr_d;
         dir_q          <= dir_d;
         line_q         <= line_d;
         moved_q        <= moved_d;
         in_move_q      <= in_move_d;
         init_q         <= init_d;
         second_q       <= second_d;
         spawn_cnt_q    <= spawn_cnt_d;
         spawn_idx_q    <= spawn_idx_d;
         spawn_val_q    <= spawn_val_d;
      end
   end

   assign board        = board_q;
   assign score        = score_q;
   assign game_over    = game_over_q;
   assign move_done    = move_done_q;
   assign move_changed = move_changed_q;
   assign busy         = (state_q != S_IDLE);
   assign move_ready   = (state_q == S_IDLE) && !game_over_q;

endmodule

// File: tb/tb_game_move_sequencer.sv
// Directed bench for game_move_sequencer: each task drives one scenario and
// compares outputs against hand-derived values; outputs sampled on negedge.
module tb_game_move_sequencer;
   localparam int CELL_W  = 20;
   localparam int SCORE_W = 21;
   localparam int BOARD_W = 16 * CELL_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 move_valid = 1'b0;
   logic [1:0]           move_dir = 2'b00;
   logic                 cfg_load = 1'b0;
   logic [BOARD_W-1:0]   cfg_board = '0;
   logic                 move_ready, busy, move_done, move_changed, game_over;
   logic [BOARD_W-1:0]   board;
   logic [SCORE_W-1:0]   score;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   game_move_sequencer #(.CELL_W(CELL_W), .SCORE_W(SCORE_W), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
      .move_ready(move_ready), .cfg_load(cfg_load), .cfg_board(cfg_board),
      .board(board), .score(score), .busy(busy), .move_done(move_done),
      .move_changed(move_changed), .game_over(game_over)
   );

   function automatic logic [CELL_W-1:0] cell_of(logic [BOARD_W-1:0] b, int r, int c);
      return b[(r*4+c)*CELL_W +: CELL_W];
   endfunction

   function automatic logic [BOARD_W-1:0] with_cell(logic [BOARD_W-1:0] b, int r, int c,
                                                     logic [CELL_W-1:0] v);
      b[(r*4+c)*CELL_W +: CELL_W] = v;
      return b;
   endfunction

   function automatic int count_nz(logic [BOARD_W-1:0] b);
      int n = 0;
      for (int i = 0; i < 16; i++) if (b[i*CELL_W +: CELL_W] != '0) n++;
      return n;
   endfunction

   function automatic logic [15:0] lfsr_step(logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   // Board expected after INIT: first spawn probes with the LFSR one step past
   // the seed (empty board, writes at once); the second spawn starts with the
   // LFSR two steps past the seed and moves on one cell if that one is taken.
   function automatic logic [BOARD_W-1:0] init_expected();
      logic [15:0] l1, l2;
      logic [3:0]  a, b;
      logic [CELL_W-1:0] va, vb;
      logic [BOARD_W-1:0] e;
      l1 = lfsr_step(16'hACE1);
      l2 = lfsr_step(l1);
      a  = l1[3:0];
      va = (l1[7:4] == 4'd0) ? 20'd4 : 20'd2;
      b  = l2[3:0];
      vb = (l2[7:4] == 4'd0) ? 20'd4 : 20'd2;
      if (b == a) b = a + 4'd1;
      e = '0;
      e[a*CELL_W +: CELL_W] = va;
      e[b*CELL_W +: CELL_W] = vb;
      return e;
   endfunction

   task automatic load(input logic [BOARD_W-1:0] b, output int cyc);
      @(negedge clk);
      cfg_board = b;
      cfg_load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfg_load = 1'b0;
      cyc = 0;
      while (busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // k = cycles after the accept cycle at which move_done is first seen.
   task automatic do_move(input logic [1:0] d, output int k, output logic seen);
      @(negedge clk);
      move_dir   = d;
      move_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      move_valid = 1'b0;
      k    = 1;
      seen = move_done;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         seen = move_done;
      end
   endtask

   task automatic test_reset();
      int cyc;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (board !== '0) begin fails++; $display("FAIL reset_board: got %h want 0", board); end
      tests++; if (score !== '0) begin fails++; $display("FAIL reset_score: got %0d want 0", score); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
      tests++; if ({move_done, move_changed, game_over, move_ready} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags: got %b want 0000", {move_done, move_changed, game_over, move_ready});
      end
      rst = 1'b0;
      cyc = 0;
      while (!move_ready && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      tests++; if (cyc > 34) begin fails++; $display("FAIL init_latency: got %0d cycles want <=34", cyc); end
      tests++; if (board !== init_expected()) begin
         fails++; $display("FAIL init_board: got %h want %h", board, init_expected());
      end
      tests++; if (count_nz(board) != 2) begin fails++; $display("FAIL init_tiles: got %0d want 2", count_nz(board)); end
      tests++; if (score !== '0) begin fails++; $display("FAIL init_score: got %0d want 0", score); end
   endtask

   task automatic test_slide_left();
      logic [BOARD_W-1:0] b;
      int cyc, k, extra;
      logic seen;
      logic [CELL_W-1:0] v;
      b = '0;
      for (int c = 0; c < 4; c++) b = with_cell(b, 0, c, 20'd2);
      load(b, cyc);
      tests++; if (cyc >= 50) begin fails++; $display("FAIL left_load: busy stuck"); end
      do_move(2'b11, k, seen);
      tests++; if (!seen) begin fails++; $display("FAIL left_done: got none want pulse"); end
      tests++; if (k < 7 || k > 22) begin fails++; $display("FAIL left_latency: got %0d want 7..22", k); end
      tests++; if (move_changed !== 1'b1) begin fails++; $display("FAIL left_changed: got %b want 1", move_changed); end
      tests++; if (cell_of(board, 0, 0) !== 20'd4 || cell_of(board, 0, 1) !== 20'd4) begin
         fails++; $display("FAIL left_row0: got %0d,%0d want 4,4", cell_of(board, 0, 0), cell_of(board, 0, 1));
      end
      tests++; if (score !== 21'd8) begin fails++; $display("FAIL left_score: got %0d want 8", score); end
      tests++; if (count_nz(board) != 3) begin fails++; $display("FAIL left_tiles: got %0d want 3", count_nz(board)); end
      extra = 0;
      for (int i = 2; i < 16; i++) begin
         v = board[i*CELL_W +: CELL_W];
         if (v != '0) begin
            extra++;
            tests++; if (v !== 20'd2 && v !== 20'd4) begin fails++; $display("FAIL left_spawn_val: got %0d want 2 or 4", v); end
         end
      end
      tests++; if (extra != 1) begin fails++; $display("FAIL left_spawn_count: got %0d want 1", extra); end
      @(negedge clk);
      tests++; if (move_done !== 1'b0 || move_ready !== 1'b1) begin
         fails++; $display("FAIL left_pulse: got done=%b ready=%b want 0,1", move_done, move_ready);
      end
   endtask

   task automatic test_merge_rules();
      logic [BOARD_W-1:0] b;
      int cyc, k;
      logic seen;
      b = with_cell(with_cell('0, 1, 0, 20'd2), 3, 0, 20'd2);
      load(b, cyc);
      do_move(2'b00, k, seen);
      tests++; if (!seen || move_changed !== 1'b1) begin fails++; $display("FAIL up_done: got seen=%b chg=%b want 1,1", seen, move_changed); end
      tests++; if (cell_of(board, 0, 0) !== 20'd4) begin fails++; $display("FAIL up_cell00: got %0d want 4", cell_of(board, 0, 0)); end
      tests++; if (score !== 21'd4) begin fails++; $display("FAIL up_score: got %0d want 4", score); end
      tests++; if (count_nz(board) != 2) begin fails++; $display("FAIL up_tiles: got %0d want 2", count_nz(board)); end
      b = with_cell(with_cell(with_cell('0, 0, 0, 20'd4), 0, 1, 20'd4), 0, 2, 20'd8);
      load(b, cyc);
      do_move(2'b11, k, seen);
      tests++; if (cell_of(board, 0, 0) !== 20'd8 || cell_of(board, 0, 1) !== 20'd8) begin
         fails++; $display("FAIL no_double_merge: got %0d,%0d want 8,8", cell_of(board, 0, 0), cell_of(board, 0, 1));
      end
      tests++; if (score !== 21'd8) begin fails++; $display("FAIL no_double_score: got %0d want 8", score); end
   endtask

   task automatic test_directions();
      logic [BOARD_W-1:0] b;
      int cyc, k;
      logic seen;
      b = with_cell(with_cell('0, 0, 2, 20'd2), 3, 2, 20'd2);
      load(b, cyc);
      do_move(2'b10, k, seen);
      tests++; if (cell_of(board, 3, 2) !== 20'd4) begin fails++; $display("FAIL down_cell32: got %0d want 4", cell_of(board, 3, 2)); end
      tests++; if (score !== 21'd4 || count_nz(board) != 2) begin
         fails++; $display("FAIL down_score_tiles: got %0d,%0d want 4,2", score, count_nz(board));
      end
      b = with_cell(with_cell(with_cell('0, 1, 1, 20'd2), 1, 2, 20'd2), 1, 3, 20'd4);
      load(b, cyc);
      do_move(2'b01, k, seen);
      tests++; if (cell_of(board, 1, 3) !== 20'd4 || cell_of(board, 1, 2) !== 20'd4) begin
         fails++; $display("FAIL right_row1: got %0d,%0d want 4,4", cell_of(board, 1, 2), cell_of(board, 1, 3));
      end
      tests++; if (score !== 21'd4 || count_nz(board) != 3) begin
         fails++; $display("FAIL right_score_tiles: got %0d,%0d want 4,3", score, count_nz(board));
      end
   endtask

   task automatic test_no_change();
      logic [BOARD_W-1:0] b;
      int cyc, k;
      logic seen;
      b = '0;
      for (int r = 0; r < 4; r++) begin
         b = with_cell(b, r, 0, 20'd2);
         b = with_cell(b, r, 1, 20'd4);
         b = with_cell(b, r, 2, 20'd8);
         b = with_cell(b, r, 3, 20'd16);
      end
      load(b, cyc);
      tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL nochg_gameover: got %b want 0", game_over); end
      do_move(2'b01, k, seen);
      tests++; if (!seen || k != 5) begin fails++; $display("FAIL nochg_latency: got %0d want 5", k); end
      tests++; if (move_changed !== 1'b0) begin fails++; $display("FAIL nochg_changed: got %b want 0", move_changed); end
      tests++; if (board !== b || score !== '0) begin fails++; $display("FAIL nochg_state: got score %0d board %h", score, board); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nochg_busy: got %b want 0", busy); end
   endtask

   task automatic test_game_over();
      logic [BOARD_W-1:0] b;
      int cyc;
      b = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b = with_cell(b, r, c, ((r + c) % 2 == 0) ? 20'd2 : 20'd4);
      load(b, cyc);
      tests++; if (game_over !== 1'b1 || move_ready !== 1'b0) begin
         fails++; $display("FAIL gameover_set: got over=%b ready=%b want 1,0", game_over, move_ready);
      end
      move_dir   = 2'b11;
      move_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tests++; if (busy !== 1'b0 || move_done !== 1'b0) begin
            fails++; $display("FAIL gameover_ignore: got busy=%b done=%b want 0,0", busy, move_done);
         end
      end
      move_valid = 1'b0;
      tests++; if (board !== b) begin fails++; $display("FAIL gameover_board: got %h want %h", board, b); end
      load('0, cyc);
      tests++; if (game_over !== 1'b0 || move_ready !== 1'b1) begin
         fails++; $display("FAIL gameover_clear: got over=%b ready=%b want 0,1", game_over, move_ready);
      end
   endtask

   task automatic test_cap_and_reset();
      logic [BOARD_W-1:0] b;
      int cyc, k;
      logic seen;
      b = with_cell(with_cell('0, 0, 0, 20'h80000), 0, 1, 20'h80000);
      load(b, cyc);
      do_move(2'b11, k, seen);
      tests++; if (!seen || k != 5 || move_changed !== 1'b0) begin
         fails++; $display("FAIL cap_nomerge: got k=%0d chg=%b want 5,0", k, move_changed);
      end
      tests++; if (board !== b || score !== '0) begin fails++; $display("FAIL cap_board: got score %0d board %h", score, board); end
      b = with_cell(with_cell('0, 0, 0, 20'd2), 0, 1, 20'd2);
      load(b, cyc);
      @(negedge clk);
      move_dir   = 2'b11;
      move_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      move_valid = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (busy !== 1'b1 || cell_of(board, 0, 0) !== 20'd4) begin
         fails++; $display("FAIL spawn_phase: got busy=%b cell00=%0d want 1,4", busy, cell_of(board, 0, 0));
      end
      rst = 1'b1;
      #1;
      tests++; if (board !== '0 || score !== '0) begin
         fails++; $display("FAIL midreset_clear: got score %0d board %h want 0", score, board);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (!move_ready && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      tests++; if (cyc > 34 || board !== init_expected()) begin
         fails++; $display("FAIL midreset_init: got %0d cycles board %h want %h", cyc, board, init_expected());
      end
      tests++; if (move_done !== 1'b0 || count_nz(board) != 2) begin
         fails++; $display("FAIL midreset_tiles: got done=%b tiles=%0d want 0,2", move_done, count_nz(board));
      end
   endtask

   initial begin
      test_reset();
      test_slide_left();
      test_merge_rules();
      test_directions();
      test_no_change();
      test_game_over();
      test_cap_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
